// File: rtl/snake_game_ctrl.sv
// Game sequencer: owns IDLE/PLAY/WIN, counts food on TARGET_REACHED rising edges, rolls new food from a free-running LFSR.
// Outputs are registered and update one edge after an input rise is seen; there is no backpressure on any port.
module snake_game_ctrl #(
    parameter int unsigned WIN_SCORE   = 10,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned FOOD_INIT_H = 40,
    parameter int unsigned FOOD_INIT_V = 30
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_ANY,
    input  logic       TARGET_REACHED,
    output logic [1:0] MASTER_STATE,
    output logic [7:0] FOOD_TARGET_H,
    output logic [6:0] FOOD_TARGET_V,
    output logic [3:0] SCORE,
    output logic       FOOD_EATEN
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10
    } state_e;

    localparam logic [3:0] WIN_SCORE_C   = 4'(WIN_SCORE);
    localparam logic [7:0] FOOD_INIT_H_C = 8'(FOOD_INIT_H);
    localparam logic [6:0] FOOD_INIT_V_C = 7'(FOOD_INIT_V);

    state_e      state_q, state_d;
    logic        btn_q, tgt_q;
    logic        btn_rise, tgt_rise;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  score_q, score_d, score_inc;
    logic [7:0]  food_h_q, food_h_d, h_map;
    logic [6:0]  food_v_q, food_v_d, v_map;
    logic        food_eaten_q, food_eaten_d;

    assign btn_rise  = BTN_ANY & ~btn_q;
    assign tgt_rise  = TARGET_REACHED & ~tgt_q;
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign score_inc = score_q + 4'd1;

    // One conditional subtract folds the raw LFSR bytes onto the 160x120 grid.
    assign h_map = (lfsr_q[7:0]  >= 8'd160) ? (lfsr_q[7:0]  - 8'd160) : lfsr_q[7:0];
    assign v_map = (lfsr_q[14:8] >= 7'd120) ? (lfsr_q[14:8] - 7'd120) : lfsr_q[14:8];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            btn_q        <= 1'b0;
            tgt_q        <= 1'b0;
            lfsr_q       <= LFSR_SEED;
            score_q      <= 4'd0;
            food_h_q     <= FOOD_INIT_H_C;
            food_v_q     <= FOOD_INIT_V_C;
            food_eaten_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= BTN_ANY;
            tgt_q        <= TARGET_REACHED;
            lfsr_q       <= lfsr_d;
            score_q      <= score_d;
            food_h_q     <= food_h_d;
            food_v_q     <= food_v_d;
            food_eaten_q <= food_eaten_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (btn_rise) state_d = ST_PLAY;
            ST_PLAY: if (tgt_rise && (score_inc == WIN_SCORE_C)) state_d = ST_WIN;
            ST_WIN:  if (btn_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // In PLAY the button is ignored, so a simultaneous button press never blocks a count.
    always_comb begin
        score_d      = score_q;
        food_h_d     = food_h_q;
        food_v_d     = food_v_q;
        food_eaten_d = 1'b0;
        case (state_q)
            ST_IDLE: if (btn_rise) score_d = 4'd0;
            ST_PLAY: begin
                if (tgt_rise) begin
                    score_d      = score_inc;
                    food_h_d     = h_map;
                    food_v_d     = v_map;
                    food_eaten_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign MASTER_STATE  = state_q;
    assign FOOD_TARGET_H = food_h_q;
    assign FOOD_TARGET_V = food_v_q;
    assign SCORE         = score_q;
    assign FOOD_EATEN    = food_eaten_q;
endmodule
